// File: rtl/awg_pkg.sv
// Shared types and constants for the AWG pattern run controller.
// Imported by the scheduler top and its helpers.
package awg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    ARM,
    RUN
  } state_t;

  localparam int CFG_BURST_W = 16;

  localparam logic [2:0] PN_MAX    = 3'd5;
  localparam logic [1:0] SYB_BPSK  = 2'd0;
  localparam logic [1:0] SYB_QPSK  = 2'd1;
  localparam logic [1:0] SYB_QAM16 = 2'd2;
  localparam logic [1:0] SYB_QAM64 = 2'd3;

  typedef struct packed {
    logic [9:0]             freq;
    logic [2:0]             pn;
    logic [1:0]             syb;
    logic [CFG_BURST_W-1:0] burst;
  } cfg_t;

endpackage

// File: rtl/awg_edge_det.sv
// Registers a generator strobe once and flags its rising edge.
// Reusable for any level-held generator status line.
module awg_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/awg_pattern_sched.sv
// Run controller: shadows config, flushes the generator, aligns to a
// pattern boundary and gates output for N patterns or continuously.
module awg_pattern_sched
  import awg_pkg::*;
#(
  parameter int FLUSH_CYC   = 4,
  parameter int ARM_TIMEOUT = 2**20-1,
  parameter int BURST_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [9:0]         cfg_freq,
  input  logic [2:0]         cfg_pn,
  input  logic [1:0]         cfg_syb,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               abort,
  input  logic               pat_sync,
  output logic [9:0]         gen_freq,
  output logic [2:0]         gen_pn,
  output logic [1:0]         gen_syb,
  output logic               gen_rst,
  output logic               out_en,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               arm_err
);

  localparam int AW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [3:0]    FLUSH_LAST = 4'(FLUSH_CYC - 1);
  localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_TIMEOUT - 1);

  state_t state, state_d;
  cfg_t   shadow, active, incoming, next_shadow;

  logic [3:0]             flush_cnt;
  logic [AW-1:0]          arm_cnt;
  logic [CFG_BURST_W-1:0] pat_cnt;
  logic sync_rise, xfer, legal, go, finish, timeout, last_pat;

  awg_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (pat_sync),
    .rise (sync_rise)
  );

  assign incoming = '{freq:  cfg_freq,
                      pn:    cfg_pn,
                      syb:   cfg_syb,
                      burst: CFG_BURST_W'(cfg_burst)};

  assign xfer  = cfg_valid & cfg_ready;
  assign legal = cfg_pn <= PN_MAX;

  // A word accepted on the start edge is bypassed straight to active.
  assign next_shadow = (xfer && legal) ? incoming : shadow;

  assign last_pat = (active.burst != '0)
                 && (pat_cnt == active.burst - 1'b1);

  always_comb begin
    state_d = state;
    go      = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    if (abort && state != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            go      = 1'b1;
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state_d = ARM;
        end
        ARM: begin
          if (sync_rise) begin
            state_d = RUN;
          end else if (arm_cnt == ARM_LAST) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
        RUN: begin
          if (start) begin
            go      = 1'b1;
            state_d = FLUSH;
          end else if (sync_rise && last_pat) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shadow    <= '0;
      active    <= '0;
      flush_cnt <= '0;
      arm_cnt   <= '0;
      pat_cnt   <= '0;
      gen_rst   <= 1'b1;
      out_en    <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      arm_err   <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_d;
      shadow    <= next_shadow;
      cfg_err   <= xfer & ~legal;
      done      <= finish;
      cfg_ready <= state_d != FLUSH;
      gen_rst   <= !(state_d == ARM || state_d == RUN);
      out_en    <= state_d == RUN;
      if (go) begin
        active    <= next_shadow;
        arm_err   <= 1'b0;
        flush_cnt <= '0;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (timeout) arm_err <= 1'b1;
      if (state != ARM) arm_cnt <= '0;
      else              arm_cnt <= arm_cnt + 1'b1;
      if (state != RUN)   pat_cnt <= '0;
      else if (sync_rise) pat_cnt <= pat_cnt + 1'b1;
    end
  end

  assign gen_freq = active.freq;
  assign gen_pn   = active.pn;
  assign gen_syb  = active.syb;
  assign busy     = state != IDLE;

endmodule

// File: tb/tb_awg_pattern_sched.sv
// Bench for awg_pattern_sched: directed scenarios plus random traffic,
// every cycle compared against a phase/countdown reference model.
module tb_awg_pattern_sched;

  localparam int FLUSH_CYC = 4;
  localparam int ARM_TO    = 100;
  localparam int BW        = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [9:0]    cfg_freq = '0;
  logic [2:0]    cfg_pn = '0;
  logic [1:0]    cfg_syb = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pat_sync = 1'b0;

  logic       cfg_ready, gen_rst, out_en, busy;
  logic       done, cfg_err, arm_err;
  logic [9:0] gen_freq;
  logic [2:0] gen_pn;
  logic [1:0] gen_syb;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  awg_pattern_sched #(
    .FLUSH_CYC   (FLUSH_CYC),
    .ARM_TIMEOUT (ARM_TO),
    .BURST_W     (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_freq  (cfg_freq),
    .cfg_pn    (cfg_pn),
    .cfg_syb   (cfg_syb),
    .cfg_burst (cfg_burst),
    .start     (start),
    .abort     (abort),
    .pat_sync  (pat_sync),
    .gen_freq  (gen_freq),
    .gen_pn    (gen_pn),
    .gen_syb   (gen_syb),
    .gen_rst   (gen_rst),
    .out_en    (out_en),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .arm_err   (arm_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 flush, 2 arm, 3 run; countdowns.
  int ph, flush_left, arm_left, pats_left;
  int sh_f, sh_p, sh_s, sh_b, ac_f, ac_p, ac_s, ac_b;
  bit prev_sync, m_ready, m_done, m_err, m_arm_err;

  function automatic void model_reset();
    ph = 0; flush_left = 0; arm_left = 0; pats_left = 0;
    sh_f = 0; sh_p = 0; sh_s = 0; sh_b = 0;
    ac_f = 0; ac_p = 0; ac_s = 0; ac_b = 0;
    prev_sync = 0; m_ready = 0;
    m_done = 0; m_err = 0; m_arm_err = 0;
  endfunction

  function automatic void model_step();
    bit rise, xf, ok;
    int nf, np, ns, nb;
    rise = pat_sync && !prev_sync;
    prev_sync = pat_sync;
    xf = cfg_valid && m_ready;
    ok = xf && (int'(cfg_pn) <= 5);
    nf = ok ? int'(cfg_freq)  : sh_f;
    np = ok ? int'(cfg_pn)    : sh_p;
    ns = ok ? int'(cfg_syb)   : sh_s;
    nb = ok ? int'(cfg_burst) : sh_b;
    m_done = 0;
    m_err = xf && !ok;
    if (abort && ph != 0) begin
      ph = 0;
    end else if (start && (ph == 0 || ph == 3)) begin
      ac_f = nf; ac_p = np; ac_s = ns; ac_b = nb;
      m_arm_err = 0;
      ph = 1;
      flush_left = FLUSH_CYC;
    end else if (ph == 1) begin
      flush_left = flush_left - 1;
      if (flush_left == 0) begin
        ph = 2;
        arm_left = ARM_TO;
      end
    end else if (ph == 2) begin
      if (rise) begin
        ph = 3;
        pats_left = ac_b;
      end else begin
        arm_left = arm_left - 1;
        if (arm_left == 0) begin
          ph = 0;
          m_arm_err = 1;
        end
      end
    end else if (ph == 3) begin
      if (rise && pats_left != 0) begin
        pats_left = pats_left - 1;
        if (pats_left == 0) begin
          ph = 0;
          m_done = 1;
        end
      end
    end
    sh_f = nf; sh_p = np; sh_s = ns; sh_b = nb;
    m_ready = (ph != 1);
  endfunction

  task automatic compare_all();
    check_eq("gen_freq", gen_freq, ac_f);
    check_eq("gen_pn", gen_pn, ac_p);
    check_eq("gen_syb", gen_syb, ac_s);
    check_eq("gen_rst", gen_rst, (ph == 0 || ph == 1));
    check_eq("out_en", out_en, (ph == 3));
    check_eq("busy", busy, (ph != 0));
    check_eq("done", done, m_done);
    check_eq("cfg_err", cfg_err, m_err);
    check_eq("arm_err", arm_err, m_arm_err);
    check_eq("cfg_ready", cfg_ready, m_ready);
    if (done) done_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_cfg(input int f, input int p,
                          input int s, input int b);
    cfg_valid = 1'b1;
    cfg_freq  = 10'(f);
    cfg_pn    = 3'(p);
    cfg_syb   = 2'(s);
    cfg_burst = BW'(b);
  endtask

  task automatic sync_pulse();
    pat_sync = 1'b1;
    step(); step();
    pat_sync = 1'b0;
    step(); step();
  endtask

  initial begin
    int hi, low, d0;
    model_reset();
    #2 rst = 1'b0;
    #1 compare_all();
    repeat (2) step();
    rst = 1'b1;
    step();
    check_eq("ready_after_rst", cfg_ready, 1);

    // Finite burst of 2 patterns
    send_cfg(9, 0, 0, 2);
    step();
    start = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gen_rst) hi++;
    end
    check_eq("flush_len", hi, FLUSH_CYC);
    d0 = done_seen;
    repeat (3) sync_pulse();
    repeat (2) step();
    check_eq("burst_done", done_seen - d0, 1);
    check_eq("idle_after_burst", busy, 0);

    // Illegal PN is rejected; old PN remains
    send_cfg(5, 6, 1, 1);
    repeat (2) step();
    start = 1'b1;
    step();
    check_eq("old_pn", gen_pn, 0);
    abort = 1'b1;
    step();

    // Continuous mode, then abort
    send_cfg(7, 3, 1, 0);
    step();
    start = 1'b1;
    repeat (8) step();
    d0 = done_seen;
    repeat (21) sync_pulse();
    check_eq("cont_out_en", out_en, 1);
    abort = 1'b1;
    step();
    check_eq("abort_gen_rst", gen_rst, 1);
    check_eq("cont_no_done", done_seen - d0, 0);

    // ARM timeout, cleared by next start
    start = 1'b1;
    repeat (FLUSH_CYC + ARM_TO + 3) step();
    check_eq("arm_timeout", arm_err, 1);
    start = 1'b1;
    step();
    check_eq("arm_err_clr", arm_err, 0);
    abort = 1'b1;
    step();

    // Config written during RUN waits for restart
    send_cfg(1, 2, 1, 1);
    step();
    start = 1'b1;
    repeat (6) step();
    sync_pulse();
    send_cfg(3, 1, 2, 5);
    step();
    check_eq("run_freq_hold", gen_freq, 1);
    check_eq("run_syb_hold", gen_syb, 1);
    start = 1'b1;
    step();
    check_eq("restart_freq", gen_freq, 3);
    check_eq("restart_syb", gen_syb, 2);
    low = cfg_ready ? 0 : 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!cfg_ready) low++;
    end
    check_eq("flush_ready_low", low, FLUSH_CYC);

    // Async reset mid-RUN
    sync_pulse();
    check_eq("pre_rst_run", out_en, 1);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("async_out_en", out_en, 0);
    step();
    rst = 1'b1;
    step();
    check_eq("ready_after_rst2", cfg_ready, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0)
        send_cfg(int'($urandom_range(1023)), int'($urandom_range(7)),
                 int'($urandom_range(3)), int'($urandom_range(3)));
      start = ($urandom_range(39) == 0);
      abort = ($urandom_range(79) == 0);
      if ($urandom_range(2) == 0) pat_sync = ~pat_sync;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
